// File: rtl/io_input_cond_if.sv
// Pin-side and core-side signal bundle for the input conditioner.
// The master drives raw pins and mode bits; the slave returns conditioned levels and pulses.
interface io_input_cond_if #(
   parameter int NUM_SW  = 32,
   parameter int NUM_BTN = 4
);
   logic [NUM_SW-1:0]  i_sw;
   logic [NUM_BTN-1:0] i_btn;
   logic [NUM_BTN-1:0] i_btn_toggle_mode;
   logic [NUM_SW-1:0]  o_sw;
   logic [NUM_BTN-1:0] o_btn;
   logic [NUM_BTN-1:0] o_btn_press;
   logic [NUM_BTN-1:0] o_btn_release;

   modport master (
      output i_sw, i_btn, i_btn_toggle_mode,
      input  o_sw, o_btn, o_btn_press, o_btn_release
   );

   modport slave (
      input  i_sw, i_btn, i_btn_toggle_mode,
      output o_sw, o_btn, o_btn_press, o_btn_release
   );
endinterface

// File: rtl/io_input_cond.sv
// Synchronises and debounces switch and button pins, normalises buttons to active-high
// and produces per-button level/toggle outputs with one-cycle press and release pulses.
module io_input_cond #(
   parameter int NUM_SW         = 32,
   parameter int NUM_BTN        = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int DB_CYCLES      = 4,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input logic         i_clk,
   input logic         i_rst_n,
   io_input_cond_if.slave bus
);
   localparam int NCH   = NUM_SW + NUM_BTN;
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
   localparam logic AL = (BTN_ACTIVE_LOW != 0);
   // Buttons idle at their raw inactive level so release from reset emits no spurious edge.
   localparam logic [NCH-1:0] RST_VAL = {{NUM_BTN{AL}}, {NUM_SW{1'b0}}};

   logic [NCH-1:0]     raw;
   logic [NCH-1:0]     sync_q [SYNC_STAGES];
   logic [NCH-1:0]     sync;
   logic [NCH-1:0]     stable_q;
   logic [CNT_W-1:0]   cnt_q [NCH];
   logic [NCH-1:0]     differ;
   logic [NCH-1:0]     accept;
   logic [NUM_BTN-1:0] pressed;
   logic [NUM_BTN-1:0] pressed_nxt;
   logic [NUM_BTN-1:0] btn_accept;
   logic [NUM_BTN-1:0] toggle_q;
   logic [NUM_BTN-1:0] press_q;
   logic [NUM_BTN-1:0] release_q;

   assign raw  = {bus.i_btn, bus.i_sw};
   assign sync = sync_q[SYNC_STAGES-1];

   // Stage: synchroniser chains
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VAL;
      end else begin
         sync_q[0] <= raw;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   always_comb begin
      differ = sync ^ stable_q;
      accept = '0;
      for (int c = 0; c < NCH; c++) accept[c] = differ[c] && (cnt_q[c] == CNT_MAX);
   end

   // Stage: debounce counters and accepted levels
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stable_q <= RST_VAL;
         for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (!differ[c]) begin
               cnt_q[c] <= '0;
            end else if (accept[c]) begin
               stable_q[c] <= sync[c];
               cnt_q[c]    <= '0;
            end else begin
               cnt_q[c] <= cnt_q[c] + 1'b1;
            end
         end
      end
   end

   assign pressed     = stable_q[NCH-1:NUM_SW] ^ {NUM_BTN{AL}};
   assign pressed_nxt = sync[NCH-1:NUM_SW] ^ {NUM_BTN{AL}};
   assign btn_accept  = accept[NCH-1:NUM_SW];

   // Stage: button events, registered on the same edge the new level is accepted
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         press_q   <= '0;
         release_q <= '0;
         toggle_q  <= '0;
      end else begin
         press_q   <= btn_accept & pressed_nxt;
         release_q <= btn_accept & ~pressed_nxt;
         toggle_q  <= bus.i_btn_toggle_mode & (toggle_q ^ (btn_accept & pressed_nxt));
      end
   end

   assign bus.o_sw          = stable_q[NUM_SW-1:0];
   assign bus.o_btn         = (bus.i_btn_toggle_mode & toggle_q) | (~bus.i_btn_toggle_mode & pressed);
   assign bus.o_btn_press   = press_q;
   assign bus.o_btn_release = release_q;
endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with default parameters: vector table plus reset sequences.
module tb_io_input_cond;
   localparam int NUM_SW  = 32;
   localparam int NUM_BTN = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   io_input_cond_if #(.NUM_SW(NUM_SW), .NUM_BTN(NUM_BTN)) bus ();

   io_input_cond #(
      .NUM_SW(NUM_SW), .NUM_BTN(NUM_BTN), .SYNC_STAGES(2),
      .DB_CYCLES(4), .BTN_ACTIVE_LOW(1)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] sw;
      logic [3:0]  btn;
      logic [3:0]  mode;
      int          n;
      logic [31:0] e_sw;
      logic [3:0]  e_btn;
      logic [3:0]  e_press;
      logic [3:0]  e_rel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input logic [31:0] sw, input logic [3:0] btn,
                      input logic [3:0] mode, input int n, input logic [31:0] e_sw,
                      input logic [3:0] e_btn, input logic [3:0] e_press, input logic [3:0] e_rel);
      vec_t v;
      v.name = nm; v.sw = sw; v.btn = btn; v.mode = mode; v.n = n;
      v.e_sw = e_sw; v.e_btn = e_btn; v.e_press = e_press; v.e_rel = e_rel;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic check_outs(input string nm, input logic [31:0] e_sw, input logic [3:0] e_btn,
                             input logic [3:0] e_press, input logic [3:0] e_rel);
      chk($sformatf("%s o_sw", nm), bus.o_sw, e_sw);
      chk($sformatf("%s o_btn", nm), 32'(bus.o_btn), 32'(e_btn));
      chk($sformatf("%s o_btn_press", nm), 32'(bus.o_btn_press), 32'(e_press));
      chk($sformatf("%s o_btn_release", nm), 32'(bus.o_btn_release), 32'(e_rel));
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic [31:0] sw, input logic [3:0] btn, input logic [3:0] mode);
      bus.i_sw = sw; bus.i_btn = btn; bus.i_btn_toggle_mode = mode;
      rst_n = 1'b0;
      adv(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with every button held (active-low 0) and every switch up.
      bus.i_sw = 32'hFFFF_FFFF; bus.i_btn = 4'h0; bus.i_btn_toggle_mode = 4'h0;
      #1 rst_n = 1'b0;
      #1 check_outs("rst_async", 32'h0, 4'h0, 4'h0, 4'h0);
      adv(2);
      rst_n = 1'b1;
      adv(5); check_outs("rst_e5", 32'h0, 4'h0, 4'h0, 4'h0);
      adv(1); check_outs("rst_e6", 32'hFFFF_FFFF, 4'hF, 4'hF, 4'h0);
      adv(1); check_outs("rst_e7", 32'hFFFF_FFFF, 4'hF, 4'h0, 4'h0);

      do_reset(32'h0, 4'hF, 4'h0);
      #1 check_outs("idle", 32'h0, 4'h0, 4'h0, 4'h0);

      // latency, press and release on btn[0]
      add("lat_e5",   32'h0, 4'hE, 4'h0, 5,  32'h0, 4'h0, 4'h0, 4'h0);
      add("lat_e6",   32'h0, 4'hE, 4'h0, 1,  32'h0, 4'h1, 4'h1, 4'h0);
      add("lat_e7",   32'h0, 4'hE, 4'h0, 1,  32'h0, 4'h1, 4'h0, 4'h0);
      add("hold_e20", 32'h0, 4'hE, 4'h0, 13, 32'h0, 4'h1, 4'h0, 4'h0);
      add("rel_e25",  32'h0, 4'hF, 4'h0, 5,  32'h0, 4'h1, 4'h0, 4'h0);
      add("rel_e26",  32'h0, 4'hF, 4'h0, 1,  32'h0, 4'h0, 4'h0, 4'h1);
      add("rel_e27",  32'h0, 4'hF, 4'h0, 1,  32'h0, 4'h0, 4'h0, 4'h0);
      // glitch rejection then acceptance on sw[5]
      add("gl_hi3",   32'h20, 4'hF, 4'h0, 3, 32'h0,  4'h0, 4'h0, 4'h0);
      add("gl_lo_a",  32'h0,  4'hF, 4'h0, 3, 32'h0,  4'h0, 4'h0, 4'h0);
      add("gl_lo_b",  32'h0,  4'hF, 4'h0, 3, 32'h0,  4'h0, 4'h0, 4'h0);
      add("sw_e5",    32'h20, 4'hF, 4'h0, 5, 32'h0,  4'h0, 4'h0, 4'h0);
      add("sw_e6",    32'h20, 4'hF, 4'h0, 1, 32'h20, 4'h0, 4'h0, 4'h0);
      add("sw_e10",   32'h20, 4'hF, 4'h0, 4, 32'h20, 4'h0, 4'h0, 4'h0);
      add("sw_clr",   32'h0,  4'hF, 4'h0, 6, 32'h0,  4'h0, 4'h0, 4'h0);
      // toggle mode on btn[1]
      add("tg_p1_e5",   32'h0, 4'hD, 4'h2, 5, 32'h0, 4'h0, 4'h0, 4'h0);
      add("tg_p1",      32'h0, 4'hD, 4'h2, 1, 32'h0, 4'h2, 4'h2, 4'h0);
      add("tg_p1_hold", 32'h0, 4'hD, 4'h2, 1, 32'h0, 4'h2, 4'h0, 4'h0);
      add("tg_r1_e5",   32'h0, 4'hF, 4'h2, 5, 32'h0, 4'h2, 4'h0, 4'h0);
      add("tg_r1",      32'h0, 4'hF, 4'h2, 1, 32'h0, 4'h2, 4'h0, 4'h2);
      add("tg_r1_hold", 32'h0, 4'hF, 4'h2, 1, 32'h0, 4'h2, 4'h0, 4'h0);
      add("tg_p2",      32'h0, 4'hD, 4'h2, 6, 32'h0, 4'h0, 4'h2, 4'h0);
      add("tg_p2_hold", 32'h0, 4'hD, 4'h2, 1, 32'h0, 4'h0, 4'h0, 4'h0);
      add("tg_r2",      32'h0, 4'hF, 4'h2, 6, 32'h0, 4'h0, 4'h0, 4'h2);
      add("tg_p3",      32'h0, 4'hD, 4'h2, 6, 32'h0, 4'h2, 4'h2, 4'h0);
      add("tg_r3",      32'h0, 4'hF, 4'h2, 6, 32'h0, 4'h2, 4'h0, 4'h2);
      add("tg_r3_hold", 32'h0, 4'hF, 4'h2, 1, 32'h0, 4'h2, 4'h0, 4'h0);
      add("tg_off",     32'h0, 4'hF, 4'h0, 1, 32'h0, 4'h0, 4'h0, 4'h0);
      add("tg_on",      32'h0, 4'hF, 4'h2, 1, 32'h0, 4'h0, 4'h0, 4'h0);
      add("tg_off2",    32'h0, 4'hF, 4'h0, 1, 32'h0, 4'h0, 4'h0, 4'h0);
      // simultaneous press of btn[2] and btn[3], then a 2-cycle bounce on btn[3]
      add("sim_e5",  32'h0, 4'h3, 4'h0, 5, 32'h0, 4'h0, 4'h0, 4'h0);
      add("sim_e6",  32'h0, 4'h3, 4'h0, 1, 32'h0, 4'hC, 4'hC, 4'h0);
      add("sim_e7",  32'h0, 4'h3, 4'h0, 1, 32'h0, 4'hC, 4'h0, 4'h0);
      add("bnc_g1",  32'h0, 4'h7, 4'h0, 1, 32'h0, 4'hC, 4'h0, 4'h0);
      add("bnc_g2",  32'h0, 4'h7, 4'h0, 1, 32'h0, 4'hC, 4'h0, 4'h0);
      for (int k = 1; k <= 6; k++)
         add($sformatf("bnc_s%0d", k), 32'h0, 4'h3, 4'h0, 1, 32'h0, 4'hC, 4'h0, 4'h0);
      add("sim_rel",      32'h0, 4'hF, 4'h0, 6, 32'h0, 4'h0, 4'h0, 4'hC);
      add("sim_rel_hold", 32'h0, 4'hF, 4'h0, 1, 32'h0, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         bus.i_sw = tbl[i].sw;
         bus.i_btn = tbl[i].btn;
         bus.i_btn_toggle_mode = tbl[i].mode;
         adv(tbl[i].n);
         check_outs(tbl[i].name, tbl[i].e_sw, tbl[i].e_btn, tbl[i].e_press, tbl[i].e_rel);
      end

      // Reset mid-debounce of a btn[0] press while other outputs are active.
      do_reset(32'h0, 4'hF, 4'h0);
      bus.i_sw = 32'hFF; bus.i_btn = 4'hD;
      adv(7); check_outs("t6_pre", 32'hFF, 4'h2, 4'h0, 4'h0);
      bus.i_btn = 4'hC;
      adv(4);
      #1 rst_n = 1'b0;
      #1 check_outs("t6_async", 32'h0, 4'h0, 4'h0, 4'h0);
      adv(2);
      rst_n = 1'b1;
      adv(5); check_outs("t6_e5", 32'h0, 4'h0, 4'h0, 4'h0);
      adv(1); check_outs("t6_e6", 32'hFF, 4'h3, 4'h3, 4'h0);
      adv(1); check_outs("t6_e7", 32'hFF, 4'h3, 4'h0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
